// File: rtl/temporizador_preparo_if.sv
// temporizador_preparo_if: command inputs, phase/status outputs of the preparation timer
// seg_restantes exists only when PREP_STATUS_EN is defined
interface temporizador_preparo_if;
  logic start_preparo, abort, venda_ini, venda_clr;
  logic press_ativo, aquec_ativo, bebida_ativo, ocupado;
  logic preparo_fim, abortado, venda_timeout;
`ifdef PREP_STATUS_EN
  logic [4:0] seg_restantes;
`endif
  modport master (
    output start_preparo, abort, venda_ini, venda_clr,
`ifdef PREP_STATUS_EN
    input seg_restantes,
`endif
    input press_ativo, aquec_ativo, bebida_ativo, ocupado, preparo_fim, abortado, venda_timeout
  );
  modport slave (
    input start_preparo, abort, venda_ini, venda_clr,
`ifdef PREP_STATUS_EN
    output seg_restantes,
`endif
    output press_ativo, aquec_ativo, bebida_ativo, ocupado, preparo_fim, abortado, venda_timeout
  );
endinterface

// File: rtl/temporizador_preparo.sv
// temporizador_preparo: press/heat/dispense sequencer plus independent sale-timeout timer
// Optional PREP_STATUS_EN adds seg_restantes (whole seconds left in the current phase).
module temporizador_preparo #(
  parameter int TICKS_PER_S = 50_000_000,
  parameter int T_PRESS     = 2,
  parameter int T_AQUEC     = 2,
  parameter int T_BEBIDA    = 5,
  parameter int T_VENDA     = 15
) (
  input logic clk3,
  input logic reset,
  temporizador_preparo_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, PRESS = 3'd1, AQUEC = 3'd2, BEBIDA = 3'd3, FIM = 3'd4;
  localparam int LP = T_PRESS * TICKS_PER_S;
  localparam int LA = T_AQUEC * TICKS_PER_S;
  localparam int LB = T_BEBIDA * TICKS_PER_S;
  localparam int LV = T_VENDA * TICKS_PER_S;
  localparam int MP = (LP > LA) ? ((LP > LB) ? LP : LB) : ((LA > LB) ? LA : LB);
  localparam int CW = $clog2(MP + 1);
  localparam int VW = $clog2(LV + 1);
  // the pulse is registered, so it must be decided one count early to land LV cycles after venda_ini
  localparam int VT = (LV > 1) ? LV - 2 : 0;
  logic [2:0] state, ns;
  logic [CW-1:0] cnt;
  logic [VW-1:0] vcnt;
  logic armed, start_ok, kill, last, vfire, vrst;
  always_comb begin
    start_ok = (state == IDLE) && bus.start_preparo && !bus.abort;
    kill = (state == PRESS || state == AQUEC || state == BEBIDA) && bus.abort;
    last = cnt == ((state == PRESS) ? CW'(LP - 1) : (state == AQUEC) ? CW'(LA - 1) : CW'(LB - 1));
    ns = kill ? IDLE :
         (state == IDLE)   ? (start_ok ? PRESS : IDLE) :
         (state == PRESS)  ? (last ? AQUEC : PRESS) :
         (state == AQUEC)  ? (last ? BEBIDA : AQUEC) :
         (state == BEBIDA) ? (last ? FIM : BEBIDA) : IDLE;
    vrst = bus.venda_clr || start_ok;
    vfire = armed && (vcnt == VW'(VT)) && !vrst && !bus.venda_ini;
  end
  always_ff @(posedge clk3 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      vcnt <= '0;
      armed <= 1'b0;
      bus.press_ativo <= 1'b0;
      bus.aquec_ativo <= 1'b0;
      bus.bebida_ativo <= 1'b0;
      bus.ocupado <= 1'b0;
      bus.preparo_fim <= 1'b0;
      bus.abortado <= 1'b0;
      bus.venda_timeout <= 1'b0;
    end else begin
      state <= ns;
      cnt <= (ns != state || state == IDLE) ? '0 : last ? cnt : cnt + 1'b1;
      bus.press_ativo <= ns == PRESS;
      bus.aquec_ativo <= ns == AQUEC;
      bus.bebida_ativo <= ns == BEBIDA;
      bus.ocupado <= ns != IDLE;
      bus.preparo_fim <= ns == FIM;
      bus.abortado <= kill;
      armed <= vrst ? 1'b0 : bus.venda_ini ? 1'b1 : armed && !vfire;
      vcnt <= (vrst || bus.venda_ini) ? '0 : (armed && !vfire) ? vcnt + 1'b1 : vcnt;
      bus.venda_timeout <= vfire;
    end
  end
`ifdef PREP_STATUS_EN
  localparam int TW = $clog2(TICKS_PER_S + 1);
  logic [TW-1:0] tk;
  logic sec_end;
  always_comb sec_end = tk == TW'(TICKS_PER_S - 1);
  always_ff @(posedge clk3 or posedge reset) begin
    if (reset) begin
      tk <= '0;
      bus.seg_restantes <= '0;
    end else begin
      tk <= (ns != state || state == IDLE || sec_end) ? '0 : tk + 1'b1;
      bus.seg_restantes <= (ns != state) ?
          ((ns == PRESS) ? 5'(T_PRESS) : (ns == AQUEC) ? 5'(T_AQUEC) : (ns == BEBIDA) ? 5'(T_BEBIDA) : 5'd0) :
          (state == IDLE) ? 5'd0 :
          (sec_end && bus.seg_restantes != 5'd0) ? bus.seg_restantes - 5'd1 : bus.seg_restantes;
    end
  end
`endif
endmodule

// File: tb/tb_temporizador_preparo.sv
// tb_temporizador_preparo: table-driven cycle checks of the preparation/sale timer (TICKS_PER_S=4)
module tb_temporizador_preparo;
  typedef struct {
    bit rs;
    int at;
    logic [3:0] in;
    logic [6:0] exp;
  } vec_t;
  localparam logic [6:0] P = 7'b1000000, A = 7'b0100000, B = 7'b0010000, O = 7'b0001000,
                         F = 7'b0000100, K = 7'b0000010, T = 7'b0000001, Z = 7'b0;
  localparam logic [3:0] S = 4'b1000, AB = 4'b0100, I = 4'b0010, C = 4'b0001, N = 4'b0;
  logic clk3 = 1'b0, reset = 1'b1;
  int cyc = 0, checks = 0, errors = 0;
  vec_t v[$];
  temporizador_preparo_if bus();
  temporizador_preparo #(.TICKS_PER_S(4)) dut (.clk3(clk3), .reset(reset), .bus(bus));
  always #5 clk3 = ~clk3;
  function automatic logic [6:0] outs();
    return {bus.press_ativo, bus.aquec_ativo, bus.bebida_ativo, bus.ocupado,
            bus.preparo_fim, bus.abortado, bus.venda_timeout};
  endfunction
  task automatic set_in(input logic [3:0] x);
    {bus.start_preparo, bus.abort, bus.venda_ini, bus.venda_clr} = x;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask
  task automatic do_reset();
    set_in(N);
    reset = 1'b1;
    repeat (2) @(posedge clk3);
    #1 reset = 1'b0;
    cyc = 0;
  endtask
  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk3);
      #1 cyc++;
      set_in(N);
    end
  endtask
  task automatic add(input bit rs, input int at, input logic [3:0] in, input logic [6:0] exp);
    vec_t e;
    e.rs = rs; e.at = at; e.in = in; e.exp = exp;
    v.push_back(e);
  endtask
  initial begin
    set_in(N);
    // normal sequence, start ignored while busy
    add(1, 0, N, Z);  add(0, 10, S, Z); add(0, 11, N, P|O); add(0, 18, N, P|O);
    add(0, 19, N, A|O); add(0, 26, N, A|O); add(0, 27, N, B|O); add(0, 30, S, B|O);
    add(0, 46, N, B|O); add(0, 47, N, F|O); add(0, 48, N, Z); add(0, 60, N, Z);
    // abort during heating
    add(1, 10, S, Z); add(0, 22, AB, A|O); add(0, 23, N, K); add(0, 24, N, Z); add(0, 47, N, Z);
    // double start, then start+abort in IDLE
    add(1, 0, S, Z); add(0, 1, N, P|O); add(0, 5, S, P|O); add(0, 36, N, B|O);
    add(0, 37, N, F|O); add(0, 38, N, Z); add(0, 39, S|AB, Z); add(0, 40, N, Z); add(0, 41, N, Z);
    // abort in FIM ignored
    add(1, 0, S, Z); add(0, 37, AB, F|O); add(0, 38, N, Z);
    // sale timer
    add(1, 0, I, Z); add(0, 59, N, Z); add(0, 60, N, T); add(0, 61, N, Z); add(0, 90, N, Z);
    add(1, 0, I, Z); add(0, 30, I, Z); add(0, 60, N, Z); add(0, 89, N, Z); add(0, 90, N, T); add(0, 91, N, Z);
    add(1, 0, I, Z); add(0, 40, C, Z); add(0, 60, N, Z); add(0, 61, N, Z);
    add(1, 0, I|C, Z); add(0, 60, N, Z); add(0, 61, N, Z);
    add(1, 0, I, Z); add(0, 10, S, Z); add(0, 47, N, F|O); add(0, 60, N, Z); add(0, 61, N, Z);
    foreach (v[i]) begin
      if (v[i].rs) do_reset();
      go(v[i].at);
      set_in(v[i].in);
      @(negedge clk3);
      chk($sformatf("vec%0d@%0d", i, v[i].at), 32'(outs()), 32'(v[i].exp));
    end
    // asynchronous reset mid-press, then a full-length run
    do_reset();
    go(10); set_in(S);
    go(15); @(negedge clk3);
    chk("pre_reset", 32'(outs()), 32'(P|O));
    #1 reset = 1'b1;
    #1 chk("async_reset", 32'(outs()), 32'(Z));
    @(posedge clk3);
    #1 reset = 1'b0;
    cyc = 0;
    go(3); set_in(S);
    go(4); @(negedge clk3); chk("after_reset_press", 32'(outs()), 32'(P|O));
    go(39); @(negedge clk3); chk("after_reset_beb", 32'(outs()), 32'(B|O));
    go(40); @(negedge clk3); chk("after_reset_fim", 32'(outs()), 32'(F|O));
    go(41); @(negedge clk3); chk("after_reset_idle", 32'(outs()), 32'(Z));
`ifdef PREP_STATUS_EN
    do_reset();
    go(10); set_in(S);
    for (int c = 10; c <= 49; c++) begin
      int e;
      go(c);
      @(negedge clk3);
      e = (c >= 11 && c <= 18) ? 2 - (c - 11) / 4 :
          (c >= 19 && c <= 26) ? 2 - (c - 19) / 4 :
          (c >= 27 && c <= 46) ? 5 - (c - 27) / 4 : 0;
      chk($sformatf("seg@%0d", c), 32'(bus.seg_restantes), 32'(e));
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
